// File: rtl/qsic_bus_pkg.sv
// qsic_bus_pkg: definitions shared by the QBUS slave front ends.
//   bus_state_t : register-cycle sequencer state encoding
//   BS7_IOPAGE  : level of bus_bs7 that selects the I/O page
//   WBE_*       : byte-enable codes presented with reg_wr
package qsic_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_READY  = 3'd2,
        ST_WSET   = 3'd3,
        ST_WSTB   = 3'd4,
        ST_RHOLD  = 3'd5,
        ST_WHOLD  = 3'd6,
        ST_IGNORE = 3'd7
    } bus_state_t;

    localparam logic       BS7_IOPAGE = 1'b1;
    localparam logic [1:0] WBE_WORD   = 2'b11;
    localparam logic [1:0] WBE_LO     = 2'b01;
    localparam logic [1:0] WBE_HI     = 2'b10;

    // Byte enables for a write: a word write enables both lanes, a byte
    // write enables the lane picked by the address byte-select bit.
    function automatic logic [1:0] wbe_for(input logic wtbt, input logic addr0);
        if (!wtbt)
            return WBE_WORD;
        return addr0 ? WBE_HI : WBE_LO;
    endfunction

endpackage

// File: rtl/edge_det.sv
// edge_det: rising-edge detector for an already-synchronised level.
//   clk  in  : system clock
//   d    in  : synchronised level
//   rise out : high for the clock in which d is 1 and was 0 on the previous edge
// The history register is deliberately not reset: it keeps tracking d while
// the system is in reset, so a line that is already high when reset is
// released is not reported as a fresh rising edge.
module edge_det (
    input  logic clk,
    input  logic d,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        prev <= d;
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/reg_cycle_seq.sv
// reg_cycle_seq: sequences QBUS slave register cycles onto the register
// read mux and the device write strobes.
//   clk, reset       : system clock, synchronous active-high reset
//   bus_sync/addr/bs7: address phase, latched on the SYNC rising edge
//   bus_din/dout     : read / write strobes (synchronised)
//   bus_wtbt/wdata   : byte-write flag and write data
//   reg_addr/reg_sel : latched address and cycle-active qualifier to decoders
//   reg_addr_match   : OR of all device match lines
//   reg_rdata        : muxed read data
//   reg_wr/wbe/wdata : one-clock write strobe with byte enables and data
//   bus_rdata/_oe    : read reply data and driver enable
//   bus_rply         : RPLY to the bus
// All control outputs are decoded from the registered state, so they are
// clean flop-timed levels.
module reg_cycle_seq
    import qsic_bus_pkg::*;
#(
    parameter int AW       = 13,
    parameter int RD_WAIT  = 2,
    parameter int WR_SETUP = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          bus_sync,
    input  logic [AW-1:0] bus_addr,
    input  logic          bus_bs7,
    input  logic          bus_din,
    input  logic          bus_dout,
    input  logic          bus_wtbt,
    input  logic [15:0]   bus_wdata,
    output logic [AW-1:0] reg_addr,
    output logic          reg_sel,
    input  logic          reg_addr_match,
    input  logic [15:0]   reg_rdata,
    output logic          reg_wr,
    output logic [1:0]    reg_wbe,
    output logic [15:0]   reg_wdata,
    output logic [15:0]   bus_rdata,
    output logic          bus_rdata_oe,
    output logic          bus_rply
);

    localparam int CMAX = (RD_WAIT > WR_SETUP) ? RD_WAIT : WR_SETUP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] WR_LAST  = CW'(WR_SETUP - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(CMAX);

    bus_state_t    state, state_next;
    logic [CW-1:0] cnt;
    logic [1:0]    wbe_q;
    logic          sync_rise;

    edge_det u_sync_edge (
        .clk  (clk),
        .d    (bus_sync),
        .rise (sync_rise)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == ST_IDLE) begin
            if (sync_rise)
                state_next = (bus_bs7 == BS7_IOPAGE) ? ST_ADDR : ST_IGNORE;
        end else if (!bus_sync) begin
            // SYNC negation aborts everything; a strobe already in WSTB is
            // a Moore output of that state and so finishes its one clock.
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_ADDR:   if (cnt == RD_LAST)
                               state_next = reg_addr_match ? ST_READY : ST_IGNORE;
                ST_READY:  if (bus_din)
                               state_next = ST_RHOLD;   // DIN wins over DOUT
                           else if (bus_dout)
                               state_next = ST_WSET;
                ST_WSET:   if (!bus_dout)
                               state_next = ST_READY;   // DOUT withdrawn before data settled
                           else if (cnt == WR_LAST)
                               state_next = ST_WSTB;
                ST_WSTB:   state_next = ST_WHOLD;
                ST_RHOLD:  if (!bus_din)  state_next = ST_READY;
                ST_WHOLD:  if (!bus_dout) state_next = ST_READY;
                default:   state_next = state;          // IGNORE waits for SYNC to drop
            endcase
        end
    end

    // Wait counter restarts on every state change and saturates.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (state_next != state)
            cnt <= '0;
        else if (cnt != CNT_SAT)
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_addr  <= '0;
            reg_wdata <= '0;
            wbe_q     <= '0;
            bus_rdata <= '0;
        end else begin
            if (state == ST_IDLE && state_next == ST_ADDR)
                reg_addr <= bus_addr;
            else if (state != ST_IGNORE && state_next == ST_IGNORE)
                reg_addr <= '0;
            if (state == ST_WSET && state_next == ST_WSTB) begin
                reg_wdata <= bus_wdata;
                wbe_q     <= wbe_for(bus_wtbt, reg_addr[0]);
            end
            // Captured once on entry to RHOLD, so it stays put while OE is up.
            if (state == ST_READY && state_next == ST_RHOLD)
                bus_rdata <= reg_rdata;
        end
    end

    assign reg_sel      = (state != ST_IDLE) && (state != ST_IGNORE);
    assign reg_wr       = (state == ST_WSTB);
    assign reg_wbe      = reg_wr ? wbe_q : 2'b00;
    assign bus_rdata_oe = (state == ST_RHOLD);
    assign bus_rply     = (state == ST_RHOLD) || (state == ST_WHOLD);

endmodule
